// File: rtl/rcc_vdd_wr_pkg.sv
// Shared types for the VDD-domain RCC write sequencer.
// State encoding, target select codes and counter sizing.
package rcc_vdd_wr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    RECOVER
  } state_e;

  localparam logic [1:0] SEL_C1_RMVF = 2'd0;
  localparam logic [1:0] SEL_C2_RMVF = 2'd1;
  localparam logic [1:0] SEL_LSION   = 2'd2;
  localparam logic [1:0] SEL_RSVD    = 2'd3;

  function automatic int cnt_width(
    input int s,
    input int h,
    input int t
  );
    int m;
    m = s;
    if (h > m) m = h;
    if (t > m) m = t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rcc_vdd_wr_ctrl_sync.sv
// Single-bit multi-flop synchroniser, clears to 0 on reset.
// Ports: clk, rst_n, d (async input), q (synchronised output).
module rcc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rcc_vdd_wr_ctrl.sv
// Sequences level-held writes into the slow VDD-domain RCC bank.
// Ports: req_* bus request, done/err/busy status, wdata/*_wren to VDD, cur_* readback, sync_* resynced readback.
module rcc_vdd_wr_ctrl
  import rcc_vdd_wr_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_wdata,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic       wdata,
  output logic       rcc_c1_rsr_rmvf_wren,
  output logic       rcc_c2_rsr_rmvf_wren,
  output logic       rcc_csr_lsion_wren,
  input  logic       cur_rcc_c1_rsr_rmvf,
  input  logic       cur_rcc_c2_rsr_rmvf,
  input  logic       cur_rcc_csr_lsion,
  output logic       sync_rmvf_c1,
  output logic       sync_rmvf_c2,
  output logic       sync_lsion
);

  localparam int CW =
    cnt_width(SETUP_CYC, HOLD_CYC, TIMEOUT_CYC);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [1:0]      sel_q;
  logic            rb;
  logic            match;

  rcc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_c1 (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cur_rcc_c1_rsr_rmvf),
    .q    (sync_rmvf_c1)
  );

  rcc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_c2 (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cur_rcc_c2_rsr_rmvf),
    .q    (sync_rmvf_c2)
  );

  rcc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lsion (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cur_rcc_csr_lsion),
    .q    (sync_lsion)
  );

  // Counter never wraps; compares use >= so a stuck max is safe.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_comb begin
    rb = 1'b0;
    case (sel_q)
      SEL_C1_RMVF: rb = sync_rmvf_c1;
      SEL_C2_RMVF: rb = sync_rmvf_c2;
      SEL_LSION:   rb = sync_lsion;
      default:     rb = 1'b0;
    endcase
  end

  // wdata stays at the latched value until return to IDLE.
  assign match     = (rb == wdata);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      sel_q                <= '0;
      wdata                <= 1'b0;
      rcc_c1_rsr_rmvf_wren <= 1'b0;
      rcc_c2_rsr_rmvf_wren <= 1'b0;
      rcc_csr_lsion_wren   <= 1'b0;
      done                 <= 1'b0;
      err                  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            sel_q <= req_sel;
            if (req_sel == SEL_RSVD) begin
              err <= 1'b1;
            end else begin
              wdata <= req_wdata;
              cnt   <= '0;
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt >= SETUP_LAST) begin
            cnt   <= '0;
            state <= PULSE;
            rcc_c1_rsr_rmvf_wren <= (sel_q == SEL_C1_RMVF);
            rcc_c2_rsr_rmvf_wren <= (sel_q == SEL_C2_RMVF);
            rcc_csr_lsion_wren   <= (sel_q == SEL_LSION);
          end else begin
            cnt <= cnt_inc;
          end
        end
        PULSE: begin
          if (cnt >= HOLD_LAST) begin
            cnt   <= '0;
            state <= RECOVER;
            rcc_c1_rsr_rmvf_wren <= 1'b0;
            rcc_c2_rsr_rmvf_wren <= 1'b0;
            rcc_csr_lsion_wren   <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RECOVER: begin
          if (match) begin
            done  <= 1'b1;
            wdata <= 1'b0;
            state <= IDLE;
          end else if (cnt >= TO_LAST) begin
            err   <= 1'b1;
            wdata <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rcc_vdd_wr_ctrl.sv
// Scoreboard bench for rcc_vdd_wr_ctrl with a behavioural VDD register model.
// Expected responses are queued at issue time; a monitor checks each cycle.
module tb_rcc_vdd_wr_ctrl;

  localparam int S = 2;
  localparam int H = 4;
  localparam int T = 64;
  localparam int Y = 2;

  typedef struct {
    int         a;
    int         r;
    logic [1:0] sel;
    logic       wd;
    logic       stuck;
    logic       is_err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_sel = 2'd0;
  logic       req_wdata = 1'b0;
  logic       done, err, busy, wdata;
  logic       wren_c1, wren_c2, wren_ls;
  logic [2:0] vdd = 3'b000;
  logic [2:0] shadow = 3'b000;
  logic       s_c1, s_c2, s_ls;

  exp_t sb[$];
  int   cyc = 0;
  int   r_last = -10;
  int   quiet = 0;
  int   vectors = 0;
  int   miscompares = 0;

  rcc_vdd_wr_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_sel             (req_sel),
    .req_wdata           (req_wdata),
    .done                (done),
    .err                 (err),
    .busy                (busy),
    .wdata               (wdata),
    .rcc_c1_rsr_rmvf_wren(wren_c1),
    .rcc_c2_rsr_rmvf_wren(wren_c2),
    .rcc_csr_lsion_wren  (wren_ls),
    .cur_rcc_c1_rsr_rmvf (vdd[0]),
    .cur_rcc_c2_rsr_rmvf (vdd[1]),
    .cur_rcc_csr_lsion   (vdd[2]),
    .sync_rmvf_c1        (s_c1),
    .sync_rmvf_c2        (s_c2),
    .sync_lsion          (s_ls)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // VDD register captures the driven data as its write enable releases.
  always @(negedge wren_c1)
    if (rst_n && sb.size() > 0 && !sb[0].stuck) vdd[0] <= wdata;
  always @(negedge wren_c2)
    if (rst_n && sb.size() > 0 && !sb[0].stuck) vdd[1] <= wdata;
  always @(negedge wren_ls)
    if (rst_n && sb.size() > 0 && !sb[0].stuck) vdd[2] <= wdata;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic issue(input logic [1:0] s, input logic w,
                       input logic stk);
    exp_t e;
    logic old;
    e.a = (cyc + 1 > r_last + 1) ? cyc + 1 : r_last + 1;
    e.sel = s;
    e.wd = w;
    e.stuck = stk;
    if (s == 2'd3) begin
      e.is_err = 1'b1;
      e.r = e.a;
    end else begin
      old = shadow[s];
      if (old == w) begin
        e.is_err = 1'b0;
        e.r = e.a + S + H + 1;
      end else if (stk) begin
        e.is_err = 1'b1;
        e.r = e.a + S + H + T;
      end else begin
        e.is_err = 1'b0;
        e.r = e.a + S + H + Y + 1;
        shadow[s] = w;
      end
    end
    sb.push_back(e);
    r_last = e.r;
    req_valid = 1'b1;
    req_sel = s;
    req_wdata = w;
    while (cyc < e.a) @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("idle_wait", 0, 1);
  endtask

  always @(negedge clk) begin : mon
    logic [2:0] ew;
    logic       ea;
    logic       ed;
    exp_t       e;
    if (rst_n) begin
      ew = 3'b000;
      ea = 1'b0;
      ed = 1'b0;
      foreach (sb[i]) begin
        if (sb[i].sel != 2'd3 && sb[i].a <= cyc && cyc < sb[i].r) begin
          ea = 1'b1;
          ed = sb[i].wd;
          if (cyc >= sb[i].a + S && cyc < sb[i].a + S + H)
            ew[sb[i].sel] = 1'b1;
        end
      end
      chk("wren", {wren_ls, wren_c2, wren_c1}, ew);
      chk("wdata", wdata, ed);
      chk("req_ready", req_ready, !ea);
      chk("busy", busy, ea);
      if (done || err) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {done, err}, 0);
        end else begin
          e = sb.pop_front();
          chk("resp_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
          chk("resp_cycle", cyc, e.r);
          quiet = cyc;
        end
      end else if (sb.size() > 0 && sb[0].r < cyc) begin
        e = sb.pop_front();
        chk("resp_missing", 0, e.r);
        quiet = cyc;
      end
      if (sb.size() == 0 && cyc >= quiet + 3)
        chk("sync", {s_ls, s_c2, s_c1}, shadow);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       sv;
    logic [1:0] rs;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    quiet = cyc;
    repeat (100) @(negedge clk);

    issue(2'd2, 1'b1, 1'b0);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("sync_lsion", s_ls, 1);

    issue(2'd0, 1'b1, 1'b1);
    wait_idle();
    issue(2'd3, 1'b1, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    issue(2'd1, 1'b1, 1'b0);
    issue(2'd0, 1'b1, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    sv = shadow[1];
    issue(2'd1, 1'b0, 1'b0);
    while (cyc < sb[0].a + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    shadow[1] = sv;
    #1;
    chk("rst_wren_c2", wren_c2, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    quiet = cyc;
    r_last = cyc;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      rs = 2'($urandom_range(0, 3));
      issue(rs, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rcc_vdd_wr_ctrl.md
Name: rcc_vdd_wr_ctrl

Overview:
- Core-domain write sequencer that drives the write side of the VDD-domain RCC register bank: the RSR remove-flag writes for CPU1/CPU2 and the CSR LSION write.
- Turns a single-cycle bus write request into a level-held wdata/wren sequence safe for the slow, level-shifted VDD-domain register.
- Resynchronises the VDD-domain readback and reports completion or timeout to the bus-side RCC register file.

Parameters:
- SETUP_CYC, 2, cycles wdata is stable before wren rises (1..15)
- HOLD_CYC, 4, cycles wren is held high (1..15)
- TIMEOUT_CYC, 64, max cycles in RECOVER waiting for readback match (4..255)
- SYNC_STAGES, 2, flops in each readback synchroniser (2..3)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  write request
- req_ready  out  1  high only in IDLE; transfer when req_valid&req_ready
- req_sel  in  2  target: 0=c1 rmvf, 1=c2 rmvf, 2=csr lsion, 3=reserved
- req_wdata  in  1  value to write
- done  out  1  one-cycle pulse, write confirmed
- err  out  1  one-cycle pulse, timeout or reserved target
- busy  out  1  state!=IDLE
- wdata  out  1  write data to VDD register
- rcc_c1_rsr_rmvf_wren  out  1  level write enable
- rcc_c2_rsr_rmvf_wren  out  1  level write enable
- rcc_csr_lsion_wren  out  1  level write enable
- cur_rcc_c1_rsr_rmvf  in  1  VDD-domain readback, asynchronous
- cur_rcc_c2_rsr_rmvf  in  1  VDD-domain readback, asynchronous
- cur_rcc_csr_lsion  in  1  VDD-domain readback, asynchronous
- sync_rmvf_c1, sync_rmvf_c2, sync_lsion  out  1 each  synchronised readback for bus reads

Behaviour:
- Reset: async on rst_n low. FSM goes to IDLE. All outputs 0 except req_ready=1. Synchronisers clear to 0.
- Reset mid-sequence drops wren and wdata in the same instant; no done/err is issued.
- FSM states: IDLE, SETUP, PULSE, RECOVER.
- IDLE: on accept, latch sel/wdata.
  - sel=3: err=1 on the next cycle, stay IDLE, no wren activity.
  - Otherwise go to SETUP with counter=0.
- SETUP: wdata=latched value, all wren 0. After SETUP_CYC cycles go to PULSE.
- PULSE: the selected wren=1, others 0, wdata held. After exactly HOLD_CYC cycles go to RECOVER.
- RECOVER: all wren 0, wdata held. Each cycle compare the selected sync_* against the latched value.
  - Match: done=1 for 1 cycle, go to IDLE.
  - TIMEOUT_CYC cycles with no match: err=1 for 1 cycle, go to IDLE.
  - done and err are mutually exclusive.
- wdata is 0 in IDLE.
- At most one wren is high at any time; never high outside PULSE.
- Latency, accept to done, with readback arriving immediately: SETUP_CYC+HOLD_CYC+SYNC_STAGES+1 cycles minimum. With defaults, done is asserted 9 cycles after the accept edge.
- Readback that already equals the written value matches on the first RECOVER cycle; this is legal.
- Requests are not queued: req_ready=0 while busy; a held req_valid is accepted on the first IDLE cycle.
- Counters: one shared down/up counter, width clog2(max(SETUP_CYC,HOLD_CYC,TIMEOUT_CYC)+1). Cleared on every state entry; no wrap (saturating compare).
- Synchronisers run continuously, independent of FSM state.

Decomposition:
- Package rcc_vdd_wr_pkg:
  - state enum (IDLE/SETUP/PULSE/RECOVER)
  - req_sel encodings (SEL_C1_RMVF, SEL_C2_RMVF, SEL_LSION, SEL_RSVD)
  - counter-width function
- Sub-module rcc_sync_bit: SYNC_STAGES-deep single-bit synchroniser, reset to 0 on rst_n, instantiated 3 times.

Test Plan:
- Reset release, no requests -> req_ready=1, all wren/wdata/done/err 0, busy 0 for 100 cycles.
- req_sel=2, req_wdata=1, cur_rcc_csr_lsion tied to rcc_csr_lsion_wren-latched model:
  - wdata=1 for 2 cycles before rcc_csr_lsion_wren
  - wren high exactly 4 cycles
  - done pulse at accept+9
  - sync_lsion=1 after
- req_sel=0, wdata=1, readback held 0 -> wren_c1 high 4 cycles, err pulse exactly 64 cycles after RECOVER entry, no done, returns IDLE.
- req_sel=3 -> err pulse next cycle, no wren ever asserted, req_ready stays 1.
- Back-to-back: req_valid held with sel=1 then sel=0 -> second accept only after the first done; c1/c2 wren never overlap.
- rst_n low during PULSE (cycle 2 of 4) -> wren_c2 and wdata 0 immediately (async); no done/err; after release, IDLE with req_ready=1.
